ysyx_220066_lsu: RTL and testbench

// Load/store unit between the CPU core's memory port and the external data bus.

---
 rtl/ysyx_220066_lsu.sv | 174 +++++++++++++++++
 tb/tb_ysyx_220066_lsu.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_220066_lsu.sv
// Load/store unit: accepts one core request, issues one aligned 64-bit bus
// transaction, and returns extended load data plus an error flag.
module ysyx_220066_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [2:0]  req_op,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  input  logic        mem_err
);

  typedef enum logic [1:0] {IDLE, MREQ, RWAIT, RESP} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [2:0]  op_q;
  logic [2:0]  off_q;
  logic        wr_q;

  logic [1:0]  size;
  logic [2:0]  off;
  logic        misaligned;
  logic [7:0]  wmask_c;
  logic [63:0] lane_mask;
  logic [63:0] wdata_c;
  logic [63:0] lane;
  logic [63:0] load_data;
  logic [7:0]  cnt_inc;
  logic        timeout_hit;

  // op 111 falls into the doubleword size class through its low two bits
  assign size        = req_op[1:0];
  assign off         = req_addr[2:0];
  assign req_ready   = (state == IDLE) && !rst;
  assign cnt_inc     = cnt + 8'd1;
  assign timeout_hit = (cnt_inc == 8'(TIMEOUT));

  // Request-side decode: alignment check, byte enables and lane-shifted store data
  always_comb begin
    misaligned = 1'b0;
    wmask_c    = '0;
    lane_mask  = '0;
    case (size)
      2'd0: wmask_c = 8'h01 << off;
      2'd1: begin
        wmask_c    = 8'h03 << off;
        misaligned = off[0];
      end
      2'd2: begin
        wmask_c    = off[2] ? 8'hF0 : 8'h0F;
        misaligned = (off[1:0] != 2'd0);
      end
      default: begin
        wmask_c    = 8'hFF;
        misaligned = (off != 3'd0);
      end
    endcase
    for (int unsigned i = 0; i < 8; i++) begin
      lane_mask[i*8 +: 8] = {8{wmask_c[i]}};
    end
    wdata_c = (req_wdata << {off, 3'b000}) & lane_mask;
  end

  // Response-side decode: pick the addressed lane and sign/zero extend it
  always_comb begin
    lane = mem_rdata >> {off_q, 3'b000};
    case (op_q[1:0])
      2'd0:    load_data = op_q[2] ? {56'd0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
      2'd1:    load_data = op_q[2] ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
      2'd2:    load_data = op_q[2] ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
      default: load_data = lane;
    endcase
  end

  // Transaction FSM with registered bus and response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      op_q       <= '0;
      off_q      <= '0;
      wr_q       <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            cnt       <= '0;
            op_q      <= req_op;
            off_q     <= off;
            wr_q      <= req_wr;
            mem_we    <= req_wr;
            mem_addr  <= {req_addr[63:3], 3'b000};
            mem_wdata <= req_wr ? wdata_c : '0;
            mem_wmask <= wmask_c;
            if (misaligned) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state     <= MREQ;
              mem_valid <= 1'b1;
            end
          end
        end
        MREQ: begin
          cnt <= cnt_inc;
          if (mem_ready) begin
            mem_valid <= 1'b0;
            if (wr_q) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= mem_err;
              resp_rdata <= '0;
            end else begin
              state <= RWAIT;
            end
          end else if (timeout_hit) begin
            mem_valid  <= 1'b0;
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end
        end
        RWAIT: begin
          cnt <= cnt_inc;
          if (mem_rvalid) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= mem_err;
            resp_rdata <= mem_err ? '0 : load_data;
          end else if (timeout_hit) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_220066_lsu.sv
// Testbench for ysyx_220066_lsu: vector table plus response scoreboard,
// with hand-written sequences for stall, timeout and reset-in-flight.
module tb_ysyx_220066_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [2:0]  req_op = '0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic        mem_err = 1'b0;

  always #5 clk = ~clk;

  ysyx_220066_lsu #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  typedef struct {
    logic        wr;
    logic [2:0]  op;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] bus_rdata;
    logic        bus_err;
    logic        misal;
    logic [63:0] exp_addr;
    logic [7:0]  exp_wmask;
    logic [63:0] exp_wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int unsigned cyc;
  } sb_t;

  vec_t        vecs[$];
  sb_t         sb[$];
  sb_t         got;
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;

  localparam logic [63:0] R1 = 64'h8090A0B0C0D0E0F0;
  localparam logic [63:0] R2 = 64'h0123456789ABCDEF;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Scoreboard: every observed response must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", {63'd0, resp_valid}, 64'd0);
      end else begin
        got = sb.pop_front();
        chk("resp_rdata", resp_rdata, got.rdata);
        chk("resp_err", {63'd0, resp_err}, {63'd0, got.err});
        chk("resp_cycle", 64'(cyc), 64'(got.cyc));
      end
    end
  end

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk({name, "_pending"}, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  // Drive request at a negedge; returns the cycle count just after the accept edge
  task automatic issue(input logic wr, input logic [2:0] op, input logic [63:0] addr,
                       input logic [63:0] wdata, output int unsigned acc);
    @(negedge clk);
    chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_wr = wr; req_op = op; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    acc = cyc;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int unsigned acc;
    int unsigned lat;
    string nm;
    nm = $sformatf("v%0d", idx);
    issue(v.wr, v.op, v.addr, v.wdata, acc);
    lat = v.misal ? 1 : (v.wr ? 2 : 3);
    sb.push_back('{v.exp_rdata, v.exp_err, acc + lat - 1});
    if (v.misal) begin
      @(negedge clk);
      chk({nm, "_no_bus"}, {63'd0, mem_valid}, 64'd0);
    end else begin
      @(negedge clk);
      chk({nm, "_mem_valid"}, {63'd0, mem_valid}, 64'd1);
      chk({nm, "_mem_addr"}, mem_addr, v.exp_addr);
      chk({nm, "_mem_we"}, {63'd0, mem_we}, {63'd0, v.wr});
      if (v.wr) begin
        chk({nm, "_wmask"}, {56'd0, mem_wmask}, {56'd0, v.exp_wmask});
        chk({nm, "_wdata"}, mem_wdata, v.exp_wdata);
      end
      mem_ready = 1'b1;
      mem_err = v.wr ? v.bus_err : 1'b0;
      @(posedge clk); #1;
      mem_ready = 1'b0; mem_err = 1'b0;
      if (!v.wr) begin
        @(negedge clk);
        chk({nm, "_rwait_valid"}, {63'd0, mem_valid}, 64'd0);
        mem_rvalid = 1'b1; mem_rdata = v.bus_rdata; mem_err = v.bus_err;
        @(posedge clk); #1;
        mem_rvalid = 1'b0; mem_err = 1'b0;
      end
    end
    drain(nm);
    if (v.misal) chk({nm, "_no_bus_after"}, {63'd0, mem_valid}, 64'd0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_req_ready"}, {63'd0, req_ready}, 64'd0);
    chk({nm, "_resp_valid"}, {63'd0, resp_valid}, 64'd0);
    chk({nm, "_resp_rdata"}, resp_rdata, 64'd0);
    chk({nm, "_resp_err"}, {63'd0, resp_err}, 64'd0);
    chk({nm, "_mem_valid"}, {63'd0, mem_valid}, 64'd0);
    chk({nm, "_mem_we"}, {63'd0, mem_we}, 64'd0);
    chk({nm, "_mem_addr"}, mem_addr, 64'd0);
    chk({nm, "_mem_wdata"}, mem_wdata, 64'd0);
    chk({nm, "_mem_wmask"}, {56'd0, mem_wmask}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc;

    //            wr    op      addr          wdata                  bus_rdata bus_err misal exp_addr      wmask  exp_wdata              exp_rdata              err
    vecs.push_back('{1'b0, 3'b000, 64'h1002, 64'h0,                 R1,  1'b0, 1'b0, 64'h1000, 8'h00, 64'h0,                 64'hFFFFFFFFFFFFFFD0, 1'b0});
    vecs.push_back('{1'b0, 3'b100, 64'h1002, 64'h0,                 R1,  1'b0, 1'b0, 64'h1000, 8'h00, 64'h0,                 64'h00000000000000D0, 1'b0});
    vecs.push_back('{1'b0, 3'b001, 64'h1004, 64'h0,                 R1,  1'b0, 1'b0, 64'h1000, 8'h00, 64'h0,                 64'hFFFFFFFFFFFFA0B0, 1'b0});
    vecs.push_back('{1'b0, 3'b101, 64'h1006, 64'h0,                 R1,  1'b0, 1'b0, 64'h1000, 8'h00, 64'h0,                 64'h0000000000008090, 1'b0});
    vecs.push_back('{1'b0, 3'b010, 64'h1004, 64'h0,                 R1,  1'b0, 1'b0, 64'h1000, 8'h00, 64'h0,                 64'hFFFFFFFF8090A0B0, 1'b0});
    vecs.push_back('{1'b0, 3'b110, 64'h1000, 64'h0,                 R1,  1'b0, 1'b0, 64'h1000, 8'h00, 64'h0,                 64'h00000000C0D0E0F0, 1'b0});
    vecs.push_back('{1'b0, 3'b011, 64'h1008, 64'h0,                 R1,  1'b0, 1'b0, 64'h1008, 8'h00, 64'h0,                 R1,                   1'b0});
    vecs.push_back('{1'b0, 3'b111, 64'h1010, 64'h0,                 R1,  1'b0, 1'b0, 64'h1010, 8'h00, 64'h0,                 R1,                   1'b0});
    vecs.push_back('{1'b0, 3'b000, 64'h1000, 64'h0,                 R2,  1'b0, 1'b0, 64'h1000, 8'h00, 64'h0,                 64'hFFFFFFFFFFFFFFEF, 1'b0});
    vecs.push_back('{1'b0, 3'b000, 64'h1007, 64'h0,                 R2,  1'b0, 1'b0, 64'h1000, 8'h00, 64'h0,                 64'h0000000000000001, 1'b0});
    vecs.push_back('{1'b0, 3'b010, 64'h1000, 64'h0,                 R1,  1'b1, 1'b0, 64'h1000, 8'h00, 64'h0,                 64'h0,                1'b1});
    vecs.push_back('{1'b1, 3'b010, 64'h1004, 64'hDEADBEEF,          64'h0, 1'b0, 1'b0, 64'h1000, 8'hF0, 64'hDEADBEEF00000000, 64'h0,                1'b0});
    vecs.push_back('{1'b1, 3'b001, 64'h1006, 64'h1234,              64'h0, 1'b0, 1'b0, 64'h1000, 8'hC0, 64'h1234000000000000, 64'h0,                1'b0});
    vecs.push_back('{1'b1, 3'b000, 64'h1003, 64'hFFFFFFFFFFFFFFAB,  64'h0, 1'b0, 1'b0, 64'h1000, 8'h08, 64'h00000000AB000000, 64'h0,                1'b0});
    vecs.push_back('{1'b1, 3'b011, 64'h2008, 64'h1122334455667788,  64'h0, 1'b0, 1'b0, 64'h2008, 8'hFF, 64'h1122334455667788, 64'h0,                1'b0});
    vecs.push_back('{1'b1, 3'b010, 64'h1000, 64'hCAFEF00D12345678,  64'h0, 1'b0, 1'b0, 64'h1000, 8'h0F, 64'h0000000012345678, 64'h0,                1'b0});
    vecs.push_back('{1'b1, 3'b000, 64'h1000, 64'h5,                 64'h0, 1'b1, 1'b0, 64'h1000, 8'h01, 64'h0000000000000005, 64'h0,                1'b1});
    vecs.push_back('{1'b0, 3'b001, 64'h1001, 64'h0,                 R1,  1'b0, 1'b1, 64'h0,    8'h00, 64'h0,                 64'h0,                1'b1});
    vecs.push_back('{1'b1, 3'b010, 64'h1002, 64'hFFFF,              64'h0, 1'b0, 1'b1, 64'h0,    8'h00, 64'h0,                 64'h0,                1'b1});
    vecs.push_back('{1'b0, 3'b011, 64'h1004, 64'h0,                 R1,  1'b0, 1'b1, 64'h0,    8'h00, 64'h0,                 64'h0,                1'b1});
    vecs.push_back('{1'b0, 3'b110, 64'h1003, 64'h0,                 R1,  1'b0, 1'b1, 64'h0,    8'h00, 64'h0,                 64'h0,                1'b1});
    vecs.push_back('{1'b0, 3'b111, 64'h1001, 64'h0,                 R1,  1'b0, 1'b1, 64'h0,    8'h00, 64'h0,                 64'h0,                1'b1});

    // Reset state
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Stalled bus: ready low for 3 cycles, stray rvalid during MREQ ignored
    issue(1'b0, 3'b011, 64'h2000, 64'h0, acc);
    sb.push_back('{64'h0011223344556677, 1'b0, acc + 5});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_mem_valid", {63'd0, mem_valid}, 64'd1);
      chk("stall_mem_addr", mem_addr, 64'h2000);
      mem_rvalid = (i == 1);
      mem_rdata = 64'hBADBADBADBADBAD0;
    end
    @(negedge clk);
    chk("stall_mem_valid_end", {63'd0, mem_valid}, 64'd1);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 64'h0011223344556677;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    drain("stall");

    // Timeout in RWAIT, then late bus handshakes ignored in IDLE
    issue(1'b0, 3'b010, 64'h3000, 64'h0, acc);
    sb.push_back('{64'h0, 1'b1, acc + 8});
    @(negedge clk);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    drain("timeout");
    @(negedge clk);
    mem_rvalid = 1'b1; mem_ready = 1'b1; mem_rdata = 64'hFFFF0000FFFF0000;
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("late_req_ready", {63'd0, req_ready}, 64'd1);
    chk("late_mem_valid", {63'd0, mem_valid}, 64'd0);

    // Asynchronous reset while waiting for read data
    issue(1'b0, 3'b011, 64'h4000, 64'h0, acc);
    @(negedge clk);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("rst_pre_mem_addr", mem_addr, 64'h4000);
    #2 rst = 1'b1;
    #1 chk_all_zero("rst_rwait");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_after_ready", {63'd0, req_ready}, 64'd1);
    run_vec(100, vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
